// File: rtl/req_arbiter.sv
// req_arbiter: single-holder request arbiter with registered one-hot grant.
// Grants are held until the holder signals done, drops its request, or the
// hold timer expires (HOLD_MAX cycles, 0 = unlimited). At least one idle
// cycle always separates consecutive grants.
// Build option: define ROUND_ROBIN_EN for rotating priority. Leave it
// undefined for fixed priority, where channel 0 is highest.
module req_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned IW       = 2,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    // Hold counter width; one bit minimum so HOLD_MAX = 0 still elaborates
    localparam int unsigned CW  = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
    localparam int unsigned HM1 = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HM1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(HOLD_MAX);

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [N-1:0]  gnt_nxt;
    logic [IW-1:0] idx_nxt;
    logic          vld_nxt;

    logic          win_any;
    logic [IW-1:0] win_idx;
    logic          grant_take;
    logic          holder_req;
    logic          timeout;
    logic          release_hold;

`ifdef ROUND_ROBIN_EN
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  ptr_nxt;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IW:0]    sum;
    logic [IW:0]    inc;

    // Rotating search: rotate req so the pointer channel lands at bit 0
    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[N-1:0];
        win_any = 1'b0;
        win_idx = '0;
        sum     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!win_any && req_rot[k]) begin
                win_any = 1'b1;
                sum     = {1'b0, ptr} + (IW+1)'(k);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                win_idx = sum[IW-1:0];
            end
        end
    end

    // Pointer advances past the winner on every new grant
    always_comb begin
        inc     = {1'b0, win_idx} + (IW+1)'(1);
        ptr_nxt = ptr;
        if (grant_take) begin
            ptr_nxt = (inc == (IW+1)'(N)) ? '0 : inc[IW-1:0];
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end
`else
    // Fixed priority: lowest asserted index wins
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!win_any && req[k]) begin
                win_any = 1'b1;
                win_idx = IW'(k);
            end
        end
    end
`endif

    // Release conditions for the current holder
    always_comb begin
        holder_req   = |(req & gnt);
        timeout      = (HOLD_MAX != 0) && (cnt == CNT_LAST);
        release_hold = done || !holder_req || timeout;
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        gnt_nxt    = gnt;
        idx_nxt    = gnt_idx;
        vld_nxt    = gnt_vld;
        grant_take = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                idx_nxt = '0;
                vld_nxt = 1'b0;
                cnt_nxt = '0;
                if (win_any) begin
                    state_nxt  = HOLD;
                    gnt_nxt    = N'(1) << win_idx;
                    idx_nxt    = win_idx;
                    vld_nxt    = 1'b1;
                    grant_take = 1'b1;
                end
            end
            HOLD: begin
                if (release_hold) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    idx_nxt   = '0;
                    vld_nxt   = 1'b0;
                    cnt_nxt   = '0;
                end else if ((HOLD_MAX != 0) && (cnt != CNT_SAT)) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                idx_nxt   = '0;
                vld_nxt   = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            gnt_vld <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: directed bench for req_arbiter with a cycle-level
// reference model and per-cycle comparison. Follows ROUND_ROBIN_EN.
module tb_req_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned IW       = 2;
    localparam int unsigned HOLD_MAX = 8;

`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic          done = 1'b0;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_vld;

    int checks   = 0;
    int failures = 0;

    req_arbiter #(.N(N), .IW(IW), .HOLD_MAX(HOLD_MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who holds the grant and for how many visible cycles
    int m_holder = -1;
    int m_len    = 0;
    int m_ptr    = 0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        int c;
        for (int k = 0; k < N; k++) begin
            c = RR ? (p + k) % N : k;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int w;
        if (rst) begin
            m_holder = -1;
            m_len    = 0;
            m_ptr    = 0;
        end else if (m_holder < 0) begin
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_holder = w;
                m_len    = 1;
                if (RR) m_ptr = (w + 1) % N;
            end
        end else if (done || !req[m_holder] || (HOLD_MAX > 0 && m_len >= HOLD_MAX)) begin
            m_holder = -1;
            m_len    = 0;
        end else begin
            m_len++;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (!rst) begin
            eg = (m_holder < 0) ? '0 : (N'(1) << m_holder);
            chk("model_gnt", 32'(gnt), 32'(eg));
            chk("model_idx", 32'(gnt_idx), (m_holder < 0) ? 32'd0 : 32'(m_holder));
            chk("model_vld", 32'(gnt_vld), 32'(m_holder >= 0));
            chk("onehot", 32'($onehot0(gnt)), 32'd1);
            chk("vld_or", 32'(gnt_vld), 32'(|gnt));
        end
    end

    logic [N-1:0] tog [4] = '{4'b1111, 4'b0011, 4'b1001, 4'b0101};
    logic [N:0]   vec [16] = '{5'b0_0011, 5'b0_0110, 5'b1_0110, 5'b0_1000,
                               5'b0_1100, 5'b0_0100, 5'b1_1111, 5'b0_1111,
                               5'b0_0000, 5'b1_0000, 5'b0_1010, 5'b0_0010,
                               5'b0_1001, 5'b1_1001, 5'b0_0111, 5'b0_0000};

    initial begin
        int ng;
        int exp_idx;
        repeat (2) @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_idx", 32'(gnt_idx), 32'd0);
        chk("reset_vld", 32'(gnt_vld), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_noreq", 32'(gnt_vld), 32'd0);

        // First grant, then release by done and re-arbitrate
        req = 4'b0101;
        @(negedge clk);
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_idx", 32'(gnt_idx), 32'd0);
        chk("first_vld", 32'(gnt_vld), 32'd1);
        done = 1'b1;
        @(negedge clk);
        chk("done_release", 32'(gnt), 32'd0);
        done = 1'b0;
        @(negedge clk);
        chk("regrant", 32'(gnt), RR ? 32'h4 : 32'h1);
        req = 4'b0000;
        @(negedge clk);
        chk("holder_drop", 32'(gnt_vld), 32'd0);

        // Other channels toggling must not disturb the holder
        req = 4'b0001;
        @(negedge clk);
        chk("hold_ch0", 32'(gnt), 32'h1);
        for (int i = 0; i < 4; i++) begin
            req = tog[i];
            @(negedge clk);
            chk("toggle_keep", 32'(gnt), 32'h1);
        end
        req = 4'b1110;
        @(negedge clk);
        chk("drop_with_others", 32'(gnt_vld), 32'd0);
        req = 4'b0000;
        @(negedge clk);

        // done in IDLE is ignored
        done = 1'b1;
        @(negedge clk);
        chk("done_idle", 32'(gnt_vld), 32'd0);
        req = 4'b0010;
        @(negedge clk);
        chk("grant_despite_done", 32'(gnt), 32'h2);
        @(negedge clk);
        chk("done_rel2", 32'(gnt_vld), 32'd0);
        done = 1'b0;
        req  = 4'b0000;
        @(negedge clk);

        // Timeout: exactly HOLD_MAX cycles high, one low, then regrant
        req = 4'b0010;
        for (int i = 0; i < HOLD_MAX; i++) begin
            @(negedge clk);
            chk("timeout_high", 32'(gnt), 32'h2);
        end
        @(negedge clk);
        chk("timeout_low", 32'(gnt_vld), 32'd0);
        @(negedge clk);
        chk("timeout_regrant", 32'(gnt), 32'h2);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Back-to-back done with all channels requesting
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        req  = 4'b1111;
        done = 1'b1;
        ng   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt_vld) begin
                exp_idx = RR ? (ng % 4) : 0;
                chk("seq_idx", 32'(gnt_idx), 32'(exp_idx));
                ng++;
            end
        end
        chk("seq_count", 32'(ng), 32'd5);
        done = 1'b0;
        req  = 4'b0000;
        repeat (2) @(negedge clk);

        // Asynchronous reset between edges drops the grant immediately
        req = 4'b0001;
        @(negedge clk);
        chk("pre_rst_vld", 32'(gnt_vld), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_idx", 32'(gnt_idx), 32'd0);
        chk("async_vld", 32'(gnt_vld), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 32'(gnt), 32'h1);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // done coincident with timeout: a single release
        req = 4'b0100;
        repeat (HOLD_MAX) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        chk("done_timeout_rel", 32'(gnt_vld), 32'd0);
        done = 1'b0;
        @(negedge clk);
        chk("done_timeout_regrant", 32'(gnt), 32'h4);

        // Directed vector table, checked by the model each cycle
        for (int i = 0; i < 16; i++) begin
            done = vec[i][N];
            req  = vec[i][N-1:0];
            repeat (2) @(negedge clk);
        end
        req  = '0;
        done = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
